countdown_scheduler: RTL and testbench

Round-robin scheduler that shares one loadable 4-bit down-counter between several requesters, each needing a timed interval. It arbitrates pending requests, loads the winner's interval length into the counter, and watches the count reach zero. It then pulses that requester's done flag and parks the counter at zero. It sits between the requesting engines and a single `synchronous_loadable_down_counter`-style datapath. That counter has no enable, so the counter runs whenever its load input is low.

---
 rtl/countdown_scheduler.sv | 132 +++++++++++++
 tb/tb_countdown_scheduler.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/countdown_scheduler.sv
// Round-robin scheduler sharing one loadable down-counter among NREQ requesters.
// All outputs are registered alongside the FSM state, so none depend on req/len/cnt_value combinationally.
module countdown_scheduler #(
    parameter int NREQ = 4,
    parameter int W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] len,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    output logic              cnt_load,
    output logic [W-1:0]      cnt_data,
    input  logic [W-1:0]      cnt_value,
    output logic [1:0]        dbg_state
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] ONE = NREQ'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_COUNT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    logic [IW-1:0]     r_idx;
    logic [IW-1:0]     r_ptr;
    logic [W-1:0]      r_len_q;
    logic [NREQ-1:0]   r_grant;
    logic [NREQ-1:0]   r_done;
    logic              r_busy;
    logic              r_cnt_load;
    logic [W-1:0]      r_cnt_data;

    logic              w_pick_valid;
    logic [IW-1:0]     w_pick_idx;
    logic [W-1:0]      w_pick_len;

    // Scan downward so the candidate closest after r_ptr is the last one written.
    always_comb begin
        int j;
        w_pick_valid = 1'b0;
        w_pick_idx   = '0;
        j            = 0;
        for (int k = NREQ; k >= 1; k--) begin
            j = (int'(r_ptr) + k) % NREQ;
            if (req[j]) begin
                w_pick_valid = 1'b1;
                w_pick_idx   = IW'(j);
            end
        end
    end

    assign w_pick_len = len[w_pick_idx*W +: W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_ptr      <= IW'(NREQ - 1);
            r_len_q    <= '0;
            r_grant    <= '0;
            r_done     <= '0;
            r_busy     <= 1'b0;
            r_cnt_load <= 1'b1;
            r_cnt_data <= '0;
        end else begin
            r_done <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_pick_valid) begin
                        r_state    <= S_LOAD;
                        r_idx      <= w_pick_idx;
                        r_len_q    <= w_pick_len;
                        r_grant    <= ONE << w_pick_idx;
                        r_busy     <= 1'b1;
                        r_cnt_load <= 1'b1;
                        r_cnt_data <= w_pick_len;
                    end
                end
                S_LOAD: begin
                    if (r_len_q == '0) begin
                        r_state    <= S_DONE;
                        r_done     <= ONE << r_idx;
                        r_cnt_load <= 1'b1;
                        r_cnt_data <= '0;
                    end else begin
                        r_state    <= S_COUNT;
                        r_cnt_load <= 1'b0;
                    end
                end
                S_COUNT: begin
                    // A withdrawn request wins over completion on the same edge.
                    if (!req[r_idx]) begin
                        r_state    <= S_IDLE;
                        r_ptr      <= r_idx;
                        r_grant    <= '0;
                        r_busy     <= 1'b0;
                        r_cnt_load <= 1'b1;
                        r_cnt_data <= '0;
                    end else if (cnt_value == W'(1)) begin
                        r_state    <= S_DONE;
                        r_done     <= ONE << r_idx;
                        r_cnt_load <= 1'b1;
                        r_cnt_data <= '0;
                    end
                end
                S_DONE: begin
                    r_state    <= S_IDLE;
                    r_ptr      <= r_idx;
                    r_grant    <= '0;
                    r_busy     <= 1'b0;
                    r_cnt_load <= 1'b1;
                    r_cnt_data <= '0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign grant     = r_grant;
    assign done      = r_done;
    assign busy      = r_busy;
    assign cnt_load  = r_cnt_load;
    assign cnt_data  = r_cnt_data;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_countdown_scheduler.sv
// Directed bench for countdown_scheduler with a behavioural loadable down-counter attached.
module tb_countdown_scheduler;
    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_COUNT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] len;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   done;
    logic              busy;
    logic              cnt_load;
    logic [W-1:0]      cnt_data;
    logic [W-1:0]      cnt_value = '0;
    logic [1:0]        dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    countdown_scheduler #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .len       (len),
        .grant     (grant),
        .done      (done),
        .busy      (busy),
        .cnt_load  (cnt_load),
        .cnt_data  (cnt_data),
        .cnt_value (cnt_value),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // External counter: loads when cnt_load is high, otherwise decrements.
    always @(posedge clk) begin
        if (cnt_load) cnt_value <= cnt_data;
        else          cnt_value <= cnt_value - W'(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_grant"},    32'(grant),     32'h0);
        check({tag, "_done"},     32'(done),      32'h0);
        check({tag, "_busy"},     32'(busy),      32'h0);
        check({tag, "_cnt_load"}, 32'(cnt_load),  32'h1);
        check({tag, "_cnt_data"}, 32'(cnt_data),  32'h0);
        check({tag, "_state"},    32'(dbg_state), 32'(ST_IDLE));
    endtask

    initial begin
        logic [NREQ-1:0] exp_g;

        rst = 1'b1;
        req = '0;
        len = '0;
        tick();
        tick();
        check_idle_outputs("reset");
        rst = 1'b0;

        // Single request, len0 = 5
        len = 16'h0005;
        req = 4'b0001;
        tick();
        check("single_grant",    32'(grant),    32'h1);
        check("single_busy",     32'(busy),     32'h1);
        check("single_load_dat", 32'(cnt_data), 32'h5);
        tick();
        check("single_cnt5",  32'(cnt_value), 32'h5);
        check("single_state", 32'(dbg_state), 32'(ST_COUNT));
        for (int k = 4; k >= 1; k--) begin
            tick();
            check("single_cnt",     32'(cnt_value), 32'(k));
            check("single_no_done", 32'(done),      32'h0);
        end
        tick();
        check("single_done",       32'(done),      32'h1);
        check("single_done_grant", 32'(grant),     32'h1);
        check("single_cnt0",       32'(cnt_value), 32'h0);
        req = '0;
        tick();
        check_idle_outputs("single_end");

        // Zero length on requester 2
        len = 16'h0000;
        req = 4'b0100;
        tick();
        check("zero_grant", 32'(grant),     32'h4);
        check("zero_state", 32'(dbg_state), 32'(ST_LOAD));
        tick();
        check("zero_done",  32'(done),      32'h4);
        check("zero_state2",32'(dbg_state), 32'(ST_DONE));
        check("zero_cnt",   32'(cnt_value), 32'h0);
        req = '0;
        tick();
        check("zero_cnt_end", 32'(cnt_value), 32'h0);
        check_idle_outputs("zero_end");

        // Round-robin from a fresh pointer: order 0,1,2,3,0, jobs 5 cycles apart
        rst = 1'b1;
        tick();
        rst = 1'b0;
        len = 16'h2222;
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            exp_g = 4'b0001 << (j % NREQ);
            tick();
            check("rr_grant", 32'(grant), 32'(exp_g));
            tick();
            tick();
            check("rr_no_done", 32'(done), 32'h0);
            tick();
            check("rr_done", 32'(done), 32'(exp_g));
            tick();
            check("rr_idle_busy", 32'(busy), 32'h0);
        end
        req = '0;
        tick();

        // Abort requester 1 when the counter reads 4; requester 3 is pending
        len = 16'h3090;
        req = 4'b0010;
        tick();
        check("abort_grant", 32'(grant), 32'h2);
        for (int k = 0; k < 6; k++) tick();
        check("abort_cnt4", 32'(cnt_value), 32'h4);
        req = 4'b1001;
        tick();
        check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
        check("abort_done",  32'(done),      32'h0);
        check("abort_grant0",32'(grant),     32'h0);
        check("abort_busy",  32'(busy),      32'h0);
        tick();
        check("abort_reload",  32'(cnt_value), 32'h0);
        check("abort_next_g3", 32'(grant),     32'h8);
        req = '0;
        tick();
        check("abort2_state", 32'(dbg_state), 32'(ST_COUNT));
        tick();
        check("abort2_idle", 32'(dbg_state), 32'(ST_IDLE));
        check("abort2_done", 32'(done),      32'h0);

        // Reset while counting at 7
        len = 16'h0009;
        req = 4'b0001;
        tick();
        check("rstmid_grant", 32'(grant), 32'h1);
        tick();
        tick();
        tick();
        check("rstmid_cnt7", 32'(cnt_value), 32'h7);
        rst = 1'b1;
        req = 4'b1111;
        len = 16'h1111;
        tick();
        check_idle_outputs("rstmid");
        rst = 1'b0;
        tick();
        check("rstmid_first_g0", 32'(grant), 32'h1);
        check("rstmid_no_done",  32'(done),  32'h0);
        // Drop request in LOAD; in COUNT with value 1 the abort must win
        req = '0;
        tick();
        check("prio_state", 32'(dbg_state), 32'(ST_COUNT));
        check("prio_cnt1",  32'(cnt_value), 32'h1);
        tick();
        check("prio_idle", 32'(dbg_state), 32'(ST_IDLE));
        check("prio_done", 32'(done),      32'h0);

        // Max length 15 on requester 0
        len = 16'h000F;
        req = 4'b0001;
        tick();
        check("max_grant", 32'(grant), 32'h1);
        for (int k = 15; k >= 1; k--) begin
            tick();
            check("max_cnt",     32'(cnt_value), 32'(k));
            check("max_state",   32'(dbg_state), 32'(ST_COUNT));
            check("max_no_done", 32'(done),      32'h0);
        end
        tick();
        check("max_done",  32'(done),      32'h1);
        check("max_cnt0",  32'(cnt_value), 32'h0);
        check("max_stdone",32'(dbg_state), 32'(ST_DONE));
        req = '0;
        tick();
        check("max_after1", 32'(cnt_value), 32'h0);
        tick();
        check("max_after2", 32'(cnt_value), 32'h0);
        check_idle_outputs("max_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
